// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency load/store responder with a byte-laned word array
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        c_we, c_uns;
    logic [31:0] c_addr, c_wdata;
    logic [1:0]  c_size;
    logic [31:0] mem [DEPTH_WORDS];
    logic        accept, commit, s_we, s_uns, err;
    logic [31:0] s_addr, s_wdata, wd, rd, sh, ld;
    logic [1:0]  s_size, lane;
    logic [3:0]  be;
    logic [AW-1:0] idx;
    // With LATENCY==1 the commit happens on the acceptance edge, so use the live request then
    always_comb begin
        accept  = (state == IDLE) && req_valid && req_ready;
        commit  = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
        s_we    = (state == IDLE) ? req_we : c_we;
        s_uns   = (state == IDLE) ? req_unsigned : c_uns;
        s_addr  = (state == IDLE) ? req_addr : c_addr;
        s_wdata = (state == IDLE) ? req_wdata : c_wdata;
        s_size  = (state == IDLE) ? req_size : c_size;
        lane    = s_addr[1:0];
        idx     = s_addr[AW+1:2];
        err     = (s_size == 2'b11) || (s_size == 2'b01 && s_addr[0]) ||
                  (s_size == 2'b10 && lane != 2'b00) ||
                  ({2'b00, s_addr[31:2]} >= 32'(DEPTH_WORDS));
        be      = (s_size == 2'b00) ? (4'b0001 << lane) :
                  (s_size == 2'b01) ? (s_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd      = (s_size == 2'b00) ? {4{s_wdata[7:0]}} :
                  (s_size == 2'b01) ? {2{s_wdata[15:0]}} : s_wdata;
        rd      = err ? 32'd0 : mem[idx];
        sh      = rd >> {lane, 3'b000};
        ld      = (s_size == 2'b00) ? (s_uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]}) :
                  (s_size == 2'b01) ? (s_uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}) : rd;
    end
    // Lane-masked store on the edge entering RESP; a reset edge never commits
    always_ff @(posedge clk) begin
        if (reset && commit && s_we && !err)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
    end
    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            c_we      <= 1'b0;
            c_uns     <= 1'b0;
            c_addr    <= 32'd0;
            c_wdata   <= 32'd0;
            c_size    <= 2'b00;
        end else begin
            rsp_valid <= 1'b0;
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= (err || s_we) ? 32'd0 : ld;
                rsp_err   <= err;
            end
            case (state)
                IDLE: if (accept) begin
                    c_we      <= req_we;
                    c_uns     <= req_unsigned;
                    c_addr    <= req_addr;
                    c_wdata   <= req_wdata;
                    c_size    <= req_size;
                    req_ready <= 1'b0;
                    state     <= (LATENCY == 1) ? RESP : WAIT;
                    cnt       <= 4'(LATENCY - 1);
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of latency, lane writes, extension, errors and reset abort
module tb_data_mem_responder;
    logic        clk, reset;
    logic        req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_size;
    logic        v1, rdy1, we1, uns1, rv1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [1:0]  size1;
    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
        .req_we(we1), .req_addr(addr1), .req_wdata(wdata1), .req_size(size1),
        .req_unsigned(uns1), .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        bit got;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1'b1;
        end
        chk({tag, "_lat"}, 32'(n), 32'd2);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_busy"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
        v1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; size1 = '0; uns1 = 1'b0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_req("sw10", 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
        do_req("lw10", 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0);
        do_req("sb13", 1, 32'h13, 32'h80, 2'b00, 0, 32'h0, 0);
        do_req("lb13", 0, 32'h13, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0);
        do_req("lbu13", 0, 32'h13, 32'h0, 2'b00, 1, 32'h00000080, 0);
        do_req("lw10b", 0, 32'h10, 32'h0, 2'b10, 1, 32'h80ADBEEF, 0);
        do_req("sh12", 1, 32'h12, 32'hFFFF1234, 2'b01, 0, 32'h0, 0);
        do_req("lw10c", 0, 32'h10, 32'h0, 2'b10, 0, 32'h1234BEEF, 0);
        do_req("lh12", 0, 32'h12, 32'h0, 2'b01, 0, 32'h00001234, 0);
        do_req("lh10", 0, 32'h10, 32'h0, 2'b01, 0, 32'hFFFFBEEF, 0);
        do_req("lhu10", 0, 32'h10, 32'h0, 2'b01, 1, 32'h0000BEEF, 0);
        do_req("lh11", 0, 32'h11, 32'h0, 2'b01, 0, 32'h0, 1);
        do_req("sw14", 1, 32'h14, 32'h11223344, 2'b10, 0, 32'h0, 0);
        do_req("sw16", 1, 32'h16, 32'hFFFFFFFF, 2'b10, 0, 32'h0, 1);
        do_req("lw14", 0, 32'h14, 32'h0, 2'b10, 0, 32'h11223344, 0);
        do_req("lw1000", 0, 32'h1000, 32'h0, 2'b10, 0, 32'h0, 1);
        do_req("sb1000", 1, 32'h1000, 32'hAA, 2'b00, 0, 32'h0, 1);
        do_req("swffc", 1, 32'hFFC, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0);
        do_req("lwffc", 0, 32'hFFC, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0);
        do_req("size11", 0, 32'h10, 32'h0, 2'b11, 0, 32'h0, 1);
        do_req("sw20", 1, 32'h20, 32'hA5A5A5A5, 2'b10, 0, 32'h0, 0);
        do_req("lw10d", 0, 32'h10, 32'h0, 2'b10, 0, 32'h1234BEEF, 0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_size = 2'b10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rdata", rsp_rdata, 32'd0);
        chk("abort_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        chk("abort_valid1", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("abort_valid2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_req("lw20", 0, 32'h20, 32'h0, 2'b10, 0, 32'hA5A5A5A5, 0);
        @(posedge clk); #1;
        v1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h12345678; size1 = 2'b10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("l1_ready%0d", k), 32'(rdy1), 32'(k % 2 == 0));
            chk($sformatf("l1_valid%0d", k), 32'(rv1), 32'(k % 2 == 1));
        end
        @(posedge clk); #1;
        we1 = 1'b0;
        @(negedge clk);
        chk("l1_ld_ready", 32'(rdy1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        @(negedge clk);
        chk("l1_ld_valid", 32'(rv1), 32'd1);
        chk("l1_ld_rdata", rdata1, 32'h12345678);
        chk("l1_ld_err", 32'(err1), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
